pe_mac_ws: RTL
==============

Name: pe_mac_ws

Overview:
- Parametrised successor to the single-config processing element. One multiply-accumulate cell of the systolic array.
- Holds a stationary weight loaded through a vertical shift chain. Forwards activations east and partial sums south, each with one-cycle latency.
- Supports a runtime signed/unsigned mode and an accumulate-in-place (output-stationary) mode.
- Tiled N x M by the array top; this spec covers one cell only.

Parameters:
- DATA_W, 8, width of activation and weight operands.
- ACC_W, 24, width of partial sum. Must satisfy ACC_W >= 2*DATA_W; elaboration error otherwise.

Ports:
- clk  input  1  system clock, rising edge
- n_rst  input  1  asynchronous active-low reset
- signed_mode  input  1  1: operands are two's complement; 0: unsigned
- weight_load  input  1  shift-enable for the weight chain
- weight_in  input  DATA_W  weight from north neighbour / array edge
- weight_out  output  DATA_W  current weight register, to south neighbour's weight_in
- act_in  input  DATA_W  activation from west
- act_valid_in  input  1  act_in qualifier
- act_out  output  DATA_W  registered activation to east
- act_valid_out  output  1  registered act_valid_in
- acc_mode  input  1  0: psum flows (psum_out = psum_in + a*w); 1: accumulate in place (psum_out = psum_out + a*w)
- acc_clear  input  1  synchronous clear of psum register
- psum_in  input  ACC_W  partial sum from north
- psum_out  output  ACC_W  registered partial sum
- psum_valid_out  output  1  psum_out updated on the last edge

Behaviour:
- Reset (n_rst low, asynchronous): the following registers go to 0 immediately and hold while n_rst is low:
  - weight_reg (so weight_out = 0)
  - act_out, act_valid_out
  - psum_out, psum_valid_out
- Reset mid-operation discards all state; no partial result survives.
- Weight chain:
  - weight_load=1: weight_reg <= weight_in on each edge; weight_out is weight_reg directly.
  - A column of R cells is loaded by R consecutive load cycles, deepest row's weight first.
  - weight_load=0: weight_reg holds.
- Activation path:
  - act_out <= act_in and act_valid_out <= act_valid_in every cycle; latency 1, unconditional.
  - act_out is updated even when invalid.
- Product:
  - p = act_in * weight_reg, 2*DATA_W bits.
  - Operands are sign-extended if signed_mode=1, zero-extended otherwise.
  - p is then sign- or zero-extended to ACC_W by the same rule.
- psum register, priority per edge:
  1. acc_clear=1: psum_out <= 0, psum_valid_out <= 0. Clear wins over a simultaneous valid activation; that activation's product is dropped.
  2. else act_valid_in=1 and acc_mode=0: psum_out <= psum_in + p.
  3. else act_valid_in=1 and acc_mode=1: psum_out <= psum_out + p (psum_in ignored).
  4. else: psum_out holds.
- psum_valid_out <= act_valid_in && !acc_clear. It is a 1-cycle pulse per valid activation.
- Simultaneous weight_load and act_valid_in: the MAC uses the weight_reg value before the edge (old weight); the new weight applies from the next cycle.
- Arithmetic overflow: sum wraps modulo 2^ACC_W, unless the optional feature is enabled.
- signed_mode and acc_mode are sampled every cycle. Changing either mid-stream takes effect on the next edge, with no flush.

Optional Feature:
- Macro: PE_MAC_SAT_EN.
- Defined:
  - The psum adder saturates. Signed mode clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; unsigned mode clamps to [0, 2^ACC_W-1].
  - Adds output sat_flag (1 bit, reset 0). sat_flag is registered high on any edge where clamping occurred and cleared only by acc_clear or reset.
- Undefined:
  - Wrapping arithmetic as above.
  - No sat_flag port.

Test Plan:
- Reset mid-stream: assert n_rst=0 asynchronously between edges during activity -> all outputs 0 before the next edge; outputs stay 0 until n_rst rises.
- Weight chain, two cascaded cells: weight_load=1 for 2 cycles with weight_in=3 then 5 -> lower cell weight_out=3, upper cell weight_out=5; both hold after load drops.
- Flow mode, signed, weight=-2 (0xFE): act_in=7 valid, psum_in=100 -> next cycle psum_out=86, psum_valid_out=1, act_out=7. Unsigned mode with the same operands -> psum_out=100+7*254=1878.
- Accumulate mode, weight=4: act_in 1,2,3 valid on consecutive cycles after acc_clear -> psum_out 4, 12, 24. acc_clear asserted with act_valid_in=1 -> psum_out=0, psum_valid_out=0.
- Load/compute collision: weight_reg=2, weight_load=1 with weight_in=9 and act_in=5 valid, psum_in=0 -> psum_out=10; the next valid act_in=5 gives 45.
- Overflow, DATA_W=8, ACC_W=16, unsigned: psum_in=0xFFF0, weight=255, act=1 -> wrap gives 0x00EF. With PE_MAC_SAT_EN -> 0xFFFF and sat_flag=1; sat_flag stays 1 until acc_clear.

Source files
------------

// File: rtl/pe_mac_ws.sv
`default_nettype none
// ============================================================================
//  Module      : pe_mac_ws
//  Description : Weight-stationary multiply-accumulate cell for a systolic
//                array. The weight is shifted in through a vertical chain,
//                activations are forwarded east and partial sums south, each
//                with one cycle of latency. Runtime signed/unsigned operand
//                mode and a flow / accumulate-in-place partial-sum mode.
//  Options     : PE_MAC_SAT_EN - when defined, the partial-sum adder
//                saturates instead of wrapping and a sticky sat_flag output
//                is added.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module pe_mac_ws #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              signed_mode,
    input  logic              weight_load,
    input  logic [DATA_W-1:0] weight_in,
    output logic [DATA_W-1:0] weight_out,
    input  logic [DATA_W-1:0] act_in,
    input  logic              act_valid_in,
    output logic [DATA_W-1:0] act_out,
    output logic              act_valid_out,
    input  logic              acc_mode,
    input  logic              acc_clear,
    input  logic [ACC_W-1:0]  psum_in,
    output logic [ACC_W-1:0]  psum_out,
    output logic              psum_valid_out
`ifdef PE_MAC_SAT_EN
    ,
    output logic              sat_flag
`endif
);

    // Full-precision product width of two DATA_W operands.
    localparam int c_prod_w = 2 * DATA_W;

    // ------------------------------------------------------------------------
    // Configuration check: the accumulator must hold a full product.
    // ------------------------------------------------------------------------
    generate
        if (ACC_W < c_prod_w) begin : g_bad_cfg
            $error("pe_mac_ws: ACC_W (%0d) must be >= 2*DATA_W (%0d)", ACC_W, c_prod_w);
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] r_weight;
    logic [DATA_W-1:0] r_act;
    logic              r_act_valid;
    logic [ACC_W-1:0]  r_psum;
    logic              r_psum_valid;

    // ------------------------------------------------------------------------
    // Datapath wires
    // ------------------------------------------------------------------------
    logic [c_prod_w-1:0] w_act_ext;
    logic [c_prod_w-1:0] w_wgt_ext;
    logic [c_prod_w-1:0] w_prod;
    logic [ACC_W-1:0]    w_prod_acc;
    logic [ACC_W-1:0]    w_base;
    logic [ACC_W-1:0]    w_sum;
    logic [ACC_W-1:0]    w_psum_next;
    logic                w_mac_en;

    // Operands are widened to the product width so a single unsigned
    // multiplier yields the correct low 2*DATA_W bits in both modes: in
    // signed mode the sign extension makes the truncated product equal to
    // the two's complement result.
    assign w_act_ext = {{DATA_W{signed_mode & act_in[DATA_W-1]}},   act_in};
    assign w_wgt_ext = {{DATA_W{signed_mode & r_weight[DATA_W-1]}}, r_weight};
    assign w_prod    = w_act_ext * w_wgt_ext;

    // Extend the product to the accumulator width by the same signedness rule.
    generate
        if (ACC_W > c_prod_w) begin : g_prod_ext
            assign w_prod_acc = {{(ACC_W - c_prod_w){signed_mode & w_prod[c_prod_w-1]}}, w_prod};
        end else begin : g_prod_noext
            assign w_prod_acc = w_prod;
        end
    endgenerate

    // Flow mode adds to the north neighbour's psum; accumulate mode adds to
    // this cell's own register and ignores psum_in.
    assign w_base   = acc_mode ? r_psum : psum_in;

    // A MAC result is written only for a valid activation not beaten by clear.
    assign w_mac_en = act_valid_in & ~acc_clear;

`ifdef PE_MAC_SAT_EN
    // ------------------------------------------------------------------------
    // Saturating adder
    // ------------------------------------------------------------------------
    localparam logic [ACC_W-1:0] c_smax = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] c_smin = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] c_umax = {ACC_W{1'b1}};

    logic [ACC_W:0]   w_sum_wide;
    logic             w_ovf_u;
    logic             w_ovf_s;
    logic             w_ovf;
    logic [ACC_W-1:0] w_sat_val;
    logic             r_sat_flag;

    assign w_sum_wide = {1'b0, w_base} + {1'b0, w_prod_acc};
    assign w_sum      = w_sum_wide[ACC_W-1:0];

    // Unsigned: the product is non-negative, so only carry-out can occur.
    assign w_ovf_u    = w_sum_wide[ACC_W];
    // Signed: operands of equal sign producing a result of the other sign.
    assign w_ovf_s    = (w_base[ACC_W-1] == w_prod_acc[ACC_W-1]) &&
                        (w_sum[ACC_W-1]  != w_base[ACC_W-1]);
    assign w_ovf      = signed_mode ? w_ovf_s : w_ovf_u;

    // Signed overflow direction follows the (shared) operand sign.
    assign w_sat_val  = signed_mode ? (w_base[ACC_W-1] ? c_smin : c_smax) : c_umax;

    assign w_psum_next = w_ovf ? w_sat_val : w_sum;

    // Sticky saturation indicator, cleared only by acc_clear or reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sat_flag <= 1'b0;
        end else if (acc_clear) begin
            r_sat_flag <= 1'b0;
        end else if (w_mac_en && w_ovf) begin
            r_sat_flag <= 1'b1;
        end
    end

    assign sat_flag = r_sat_flag;
`else
    // ------------------------------------------------------------------------
    // Wrapping adder (modulo 2^ACC_W)
    // ------------------------------------------------------------------------
    assign w_sum       = w_base + w_prod_acc;
    assign w_psum_next = w_sum;
`endif

    // Weight chain: shift in from the north when loading, otherwise hold.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_weight <= '0;
        end else if (weight_load) begin
            r_weight <= weight_in;
        end
    end

    // Activation forwarding east: unconditional one-cycle delay, data too.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_act       <= '0;
            r_act_valid <= 1'b0;
        end else begin
            r_act       <= act_in;
            r_act_valid <= act_valid_in;
        end
    end

    // Partial-sum register: clear has priority, then MAC update, else hold.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_psum       <= '0;
            r_psum_valid <= 1'b0;
        end else begin
            r_psum_valid <= w_mac_en;
            if (acc_clear) begin
                r_psum <= '0;
            end else if (act_valid_in) begin
                r_psum <= w_psum_next;
            end
        end
    end

    assign weight_out     = r_weight;
    assign act_out        = r_act;
    assign act_valid_out  = r_act_valid;
    assign psum_out       = r_psum;
    assign psum_valid_out = r_psum_valid;

endmodule : pe_mac_ws
`default_nettype wire
